// File: rtl/sm_arbiter.sv
// Round-robin front end for one shared sequential multiplier.
// One job is in flight at a time: grant in IDLE, pulse start, wait for a
// fresh done (or a watchdog abort), then return the result to the owner.
module sm_arbiter #(
  parameter int WIDTH          = 16,
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clock,
  input  logic                   reset_in,
  input  logic [N_REQ-1:0]       req_in,
  input  logic [N_REQ*WIDTH-1:0] multiplicand_in,
  input  logic [N_REQ*WIDTH-1:0] multiplier_in,
  output logic [N_REQ-1:0]       ack_out,
  output logic                   mult_start_out,
  output logic [WIDTH-1:0]       mult_a_out,
  output logic [WIDTH-1:0]       mult_b_out,
  input  logic                   mult_done_in,
  input  logic [WIDTH-1:0]       mult_product_in,
  input  logic                   mult_overflow_in,
  output logic [N_REQ-1:0]       resp_valid_out,
  output logic [WIDTH-1:0]       product_out,
  output logic                   overflow_out,
  output logic                   timeout_out,
  output logic                   busy_out
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] grant_idx;
  logic [WD_W-1:0]  wdog;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             wd_expired;
  logic             do_grant;
  logic             do_issue;
  logic             do_done;
  logic             do_abort;
  logic             wd_run;

  // First requester found scanning last+1, last+2, ... (mod N_REQ).
  // Scanning from farthest to nearest lets the nearest hit win.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [IDX_W-1:0] last);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[IDX_W'(idx)]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign {pick_vld, pick_idx} = rr_pick(req_in, last_grant);
  assign wd_expired           = (wdog == WD_LAST);
  assign busy_out             = (state != S_IDLE);

  // State register.
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state decode and one-cycle action strobes for the datapath.
  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    do_issue   = 1'b0;
    do_done    = 1'b0;
    do_abort   = 1'b0;
    wd_run     = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          do_grant   = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        do_issue   = 1'b1;
        state_next = S_ARM;
      end
      S_ARM: begin
        // A done still high from the previous job must drop before we trust it.
        wd_run = 1'b1;
        if (wd_expired) begin
          do_abort   = 1'b1;
          state_next = S_RESP;
        end else if (!mult_done_in) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        wd_run = 1'b1;
        if (mult_done_in) begin
          do_done    = 1'b1;
          state_next = S_RESP;
        end else if (wd_expired) begin
          do_abort   = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Grant capture, start pulse, watchdog and result registers.
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      ack_out        <= '0;
      mult_start_out <= 1'b0;
      mult_a_out     <= '0;
      mult_b_out     <= '0;
      resp_valid_out <= '0;
      product_out    <= '0;
      overflow_out   <= 1'b0;
      timeout_out    <= 1'b0;
      last_grant     <= LAST_RESET;
      grant_idx      <= '0;
      wdog           <= '0;
    end else begin
      ack_out        <= '0;
      resp_valid_out <= '0;
      mult_start_out <= do_issue;
      if (do_grant) begin
        ack_out    <= onehot(pick_idx);
        grant_idx  <= pick_idx;
        last_grant <= pick_idx;
        mult_a_out <= multiplicand_in[int'(pick_idx) * WIDTH +: WIDTH];
        mult_b_out <= multiplier_in[int'(pick_idx) * WIDTH +: WIDTH];
      end
      if (do_issue)    wdog <= '0;
      else if (wd_run) wdog <= wdog + 1'b1;
      if (do_done) begin
        resp_valid_out <= onehot(grant_idx);
        product_out    <= mult_product_in;
        overflow_out   <= mult_overflow_in;
        timeout_out    <= 1'b0;
      end else if (do_abort) begin
        resp_valid_out <= onehot(grant_idx);
        product_out    <= '0;
        overflow_out   <= 1'b0;
        timeout_out    <= 1'b1;
      end
    end
  end

endmodule
